sbus_mem_responder: RTL and testbench
=====================================

# sbus_mem_responder

Memory-side responder for the cache/PMA physical-address interface: accepts a physical-address request (PA[14:35], address parity, word-request mask, read/write type), acknowledges it, then either returns the requested quadword words or absorbs write data. It sits at the far end of the path the PMA drives, standing in for an MF20-class memory controller in simulation and FPGA builds. It is the memory model behind every MBOX cycle: core reads, writebacks, page refills and channel transfers.

## Interface
- MEM_WORDS, 4096: implemented words; addresses at or above this are non-existent.
- ACCESS_CYC, 3: core access cycles between ACKN and the first data beat; must be at least 1.
- clk  in  1  system clock.
- CROBAR  in  1  synchronous, active-high reset.
- START  in  1  request strobe; sampled only in IDLE.
- WR_RQ  in  1  1 = write cycle, 0 = read cycle.
- RQ  in  4 [0:3]  word-request mask; bit n selects quadword word n.
- ADR  in  22 [14:35]  physical address; [14:33] is the quadword base, [34:35] is the first word.
- ADR_PAR  in  1  odd parity over ADR[14:33].
- DATA_IN  in  36 [0:35]  write data.
- DATA_IN_PAR  in  1  odd parity over DATA_IN.
- DATA_IN_VALID  in  1  write data beat strobe.
- ACKN  out  1  request accepted, one-cycle pulse.
- BUSY  out  1  request in progress.
- DATA_OUT  out  36 [0:35]  read data.
- DATA_OUT_PAR  out  1  odd parity over DATA_OUT.
- DATA_OUT_VALID  out  1  read data beat strobe.
- NXM  out  1  non-existent memory, one-cycle pulse.
- ADR_PAR_ERR  out  1  address parity error, one-cycle pulse.
- DATA_PAR_ERR  out  1  sticky write-data parity error; cleared on the next accepted START.

## Operation
- States: IDLE, ACK, ACCESS, RD_XFER, WR_XFER.
- IDLE with START: latch ADR, RQ and WR_RQ, then check the request.
  - Address parity bad (macro on): pulse ADR_PAR_ERR and stay IDLE.
  - Word address (ADR[14:35]) >= MEM_WORDS: pulse NXM and stay IDLE.
  - Otherwise go to ACK.
- ACK: ACKN=1 for one cycle.
  - RQ=0000: go to IDLE.
  - Otherwise go to ACCESS and load the counter with ACCESS_CYC.
- ACCESS: decrement the counter. At 1, go to RD_XFER if WR_RQ=0, else WR_XFER.
- Word order is wrap order: first word ADR[34:35], then +1 mod 4, for four slots. A slot whose RQ bit is 0 is skipped with no cycle spent. Each word's address is {ADR[14:33], slot}.
- RD_XFER: one requested word per cycle, back-to-back, with DATA_OUT_VALID=1. After the last requested word, go to IDLE.
- WR_XFER: the current requested word is written on each cycle with DATA_IN_VALID=1; the block waits indefinitely between beats. After the last requested word, go to IDLE.
- BUSY=1 in every state except IDLE. START while BUSY is ignored.
- DATA_OUT is 0 whenever DATA_OUT_VALID=0.
- CROBAR in any state: next state IDLE, all outputs 0, counter 0. Memory contents are preserved.

## Timing
- Reset values: ACKN, BUSY, DATA_OUT, DATA_OUT_PAR, DATA_OUT_VALID, NXM, ADR_PAR_ERR and DATA_PAR_ERR are all 0.
- START in cycle t:
  - ACKN at t+1.
  - First read beat at t+2+ACCESS_CYC. With RQ=1111 the last beat is at t+5+ACCESS_CYC, and BUSY falls at t+6+ACCESS_CYC.
  - NXM or ADR_PAR_ERR pulse appears at t+1, in place of ACKN.
- A new START is accepted in the first IDLE cycle after BUSY falls.
- DATA_IN_VALID in the same cycle WR_XFER is entered counts as a beat. DATA_IN_VALID outside WR_XFER is ignored.
- Memory read is registered: the array address is presented one cycle ahead of each beat.

## Configuration
- SBUS_PAR_CHECK_EN defined:
  - ADR_PAR is checked on START.
  - DATA_IN_PAR is checked on each write beat. A bad beat is not written, sets DATA_PAR_ERR, and still advances to the next word.
- SBUS_PAR_CHECK_EN undefined:
  - ADR_PAR and DATA_IN_PAR are ignored.
  - ADR_PAR_ERR and DATA_PAR_ERR are tied to 0.
- DATA_OUT_PAR is generated in both builds.

## Structure
- Shared package sbus_pkg holds:
  - the state enum;
  - typedefs for the 36-bit word and the PA[14:35] address;
  - odd-parity functions for 20-bit and 36-bit vectors.
- Sub-module sbus_mem_array: single-port synchronous RAM with MEM_WORDS x 36 bits, registered read output and write enable. It has no reset.

## Test plan
- Write RQ=1111, ADR=0o000100, data 1,2,3,4; then read RQ=1111 at the same ADR -> ACKN at t+1, DATA_OUT 1,2,3,4 on four consecutive cycles starting at t+5 (ACCESS_CYC=3).
- Read RQ=1010, ADR[34:35]=2 -> beats in order word 2, then word 0; exactly two DATA_OUT_VALID cycles.
- ADR = MEM_WORDS -> NXM pulse at t+1, no ACKN, BUSY stays 0.
- Macro on, ADR_PAR inverted -> ADR_PAR_ERR at t+1, no access. Write beat with bad DATA_IN_PAR -> DATA_PAR_ERR=1, old word retained.
- START during RD_XFER ignored. RQ=0000 -> ACKN only, BUSY=1 for one cycle.
- CROBAR asserted during WR_XFER after two beats -> IDLE next cycle; re-reading shows the two written words and old values for the rest.

Source files
------------

// File: rtl/sbus_pkg.sv
// Shared types and helpers for the SBUS memory responder.
// PDP-10 bit numbering: bit 0 is the most significant bit of a word.
package sbus_pkg;

    typedef logic [0:35]  sbus_word_t;
    typedef logic [14:35] sbus_pa_t;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACK     = 3'd1;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_RD_XFER = 3'd3;
    localparam logic [2:0] S_WR_XFER = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_ACK     = S_ACK,
        ST_ACCESS  = S_ACCESS,
        ST_RD_XFER = S_RD_XFER,
        ST_WR_XFER = S_WR_XFER
    } sbus_state_t;

    // Odd parity bit: the data plus this bit always holds an odd number of ones.
    function automatic logic odd_par20(input logic [19:0] d);
        return ~^d;
    endfunction

    function automatic logic odd_par36(input sbus_word_t d);
        return ~^d;
    endfunction

    // One-hot mask selecting quadword slot s in a [0:3] word-request mask.
    function automatic logic [0:3] slot_bit(input logic [1:0] s);
        return 4'b1000 >> s;
    endfunction

    // First requested slot at or after 'start' in wrap order (start, start+1, ... mod 4).
    function automatic logic [1:0] first_req(input logic [0:3] mask, input logic [1:0] start);
        logic [1:0] s;
        logic [1:0] r;
        logic       found;
        r     = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = start + 2'(i);
            if (!found && mask[s]) begin
                r     = s;
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sbus_mem_array.sv
// Single-port synchronous word RAM with registered read data.
// Read-before-write on a shared address; contents are never reset.
module sbus_mem_array
    import sbus_pkg::*;
#(
    parameter int WORDS = 4096,
    parameter int AW    = 12
)
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [0:35]   wdata,
    output logic [0:35]   rdata
);

    sbus_word_t mem [WORDS];
    sbus_word_t rdata_q;

    // Write on enable; the read port samples the same address every cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sbus_mem_responder.sv
// Memory-side responder for the PMA physical-address interface.
// Accepts a request, acknowledges it, waits the core access time, then
// streams requested quadword words in wrap order (read) or absorbs write beats.
// Build option: define SBUS_PAR_CHECK_EN to check address and write-data parity.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for START; rejects bad parity / non-existent address
// ACK        | ACKN pulse; empty request mask returns straight to IDLE
// ACCESS     | core access delay; last cycle presents the first read address
// RD_XFER    | one requested word per cycle, next address presented ahead
// WR_XFER    | one requested word per DATA_IN_VALID beat, waits between beats
module sbus_mem_responder
    import sbus_pkg::*;
#(
    parameter int MEM_WORDS  = 4096,
    parameter int ACCESS_CYC = 3
)
(
    input  logic        clk,
    input  logic        CROBAR,
    input  logic        START,
    input  logic        WR_RQ,
    input  logic [0:3]  RQ,
    input  logic [14:35] ADR,
    input  logic        ADR_PAR,
    input  logic [0:35] DATA_IN,
    input  logic        DATA_IN_PAR,
    input  logic        DATA_IN_VALID,
    output logic        ACKN,
    output logic        BUSY,
    output logic [0:35] DATA_OUT,
    output logic        DATA_OUT_PAR,
    output logic        DATA_OUT_VALID,
    output logic        NXM,
    output logic        ADR_PAR_ERR,
    output logic        DATA_PAR_ERR
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam int          CW        = $clog2(ACCESS_CYC + 1);
    localparam logic [21:0] MEM_LIMIT = 22'(MEM_WORDS);

    sbus_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-3:0] base_q, base_d;
    logic [1:0]    slot_q, slot_d;
    logic [0:3]    pend_q, pend_d;
    logic          wr_q, wr_d;
    logic          nxm_q, nxm_d;
    logic          ape_q, ape_d;
    logic          dpe_q, dpe_d;

    logic [21:0]   adr_num;
    logic [0:3]    pend_next;
    logic          adr_par_ok;
    logic          din_par_ok;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [0:35]   mem_rdata;

    assign adr_num = ADR;

`ifdef SBUS_PAR_CHECK_EN
    assign adr_par_ok   = (odd_par20(ADR[14:33]) == ADR_PAR);
    assign din_par_ok   = (odd_par36(DATA_IN) == DATA_IN_PAR);
    assign ADR_PAR_ERR  = ape_q;
    assign DATA_PAR_ERR = dpe_q;
`else
    logic par_unused;
    assign par_unused   = ^{ADR_PAR, DATA_IN_PAR, ape_q, dpe_q};
    assign adr_par_ok   = 1'b1;
    assign din_par_ok   = 1'b1;
    assign ADR_PAR_ERR  = 1'b0;
    assign DATA_PAR_ERR = 1'b0;
`endif

    // Next-state, slot sequencing and memory port control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        slot_d    = slot_q;
        pend_d    = pend_q;
        wr_d      = wr_q;
        nxm_d     = 1'b0;
        ape_d     = 1'b0;
        dpe_d     = dpe_q;
        mem_we    = 1'b0;
        mem_addr  = {base_q, slot_q};
        pend_next = pend_q & ~slot_bit(slot_q);

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    base_d = adr_num[AW-1:2];
                    slot_d = adr_num[1:0];
                    pend_d = RQ;
                    wr_d   = WR_RQ;
                    if (!adr_par_ok) begin
                        ape_d = 1'b1;
                    end else if (adr_num >= MEM_LIMIT) begin
                        nxm_d = 1'b1;
                    end else begin
                        state_d = ST_ACK;
                        dpe_d   = 1'b0;
                    end
                end
            end
            ST_ACK: begin
                if (pend_q == 4'b0000) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACCESS;
                    cnt_d   = CW'(ACCESS_CYC);
                    slot_d  = first_req(pend_q, slot_q);
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = wr_q ? ST_WR_XFER : ST_RD_XFER;
                end
            end
            ST_RD_XFER: begin
                pend_d = pend_next;
                if (pend_next == 4'b0000) begin
                    state_d = ST_IDLE;
                end else begin
                    slot_d   = first_req(pend_next, slot_q);
                    mem_addr = {base_q, slot_d};
                end
            end
            ST_WR_XFER: begin
                if (DATA_IN_VALID) begin
                    if (din_par_ok) begin
                        mem_we = 1'b1;
                    end else begin
                        dpe_d = 1'b1;
                    end
                    pend_d = pend_next;
                    if (pend_next == 4'b0000) begin
                        state_d = ST_IDLE;
                    end else begin
                        slot_d = first_req(pend_next, slot_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers with synchronous CROBAR reset.
    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            slot_q  <= '0;
            pend_q  <= '0;
            wr_q    <= 1'b0;
            nxm_q   <= 1'b0;
            ape_q   <= 1'b0;
            dpe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            slot_q  <= slot_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            nxm_q   <= nxm_d;
            ape_q   <= ape_d;
            dpe_q   <= dpe_d;
        end
    end

    sbus_mem_array #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (DATA_IN),
        .rdata (mem_rdata)
    );

    assign ACKN           = (state_q == ST_ACK);
    assign BUSY           = (state_q != ST_IDLE);
    assign NXM            = nxm_q;
    assign DATA_OUT_VALID = (state_q == ST_RD_XFER);
    assign DATA_OUT       = DATA_OUT_VALID ? mem_rdata : '0;
    assign DATA_OUT_PAR   = DATA_OUT_VALID & odd_par36(mem_rdata);

endmodule

// File: tb/tb_sbus_mem_responder.sv
// Bench for sbus_mem_responder: a memory model and an expected-beat queue
// are filled as requests are driven; read beats are popped and compared.
module tb_sbus_mem_responder;

    localparam int MEM_WORDS  = 4096;
    localparam int ACCESS_CYC = 3;
`ifdef SBUS_PAR_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         CROBAR = 1'b1;
    logic         START = 1'b0;
    logic         WR_RQ = 1'b0;
    logic [0:3]   RQ = '0;
    logic [14:35] ADR = '0;
    logic         ADR_PAR = 1'b0;
    logic [0:35]  DATA_IN = '0;
    logic         DATA_IN_PAR = 1'b0;
    logic         DATA_IN_VALID = 1'b0;
    logic         ACKN, BUSY, DATA_OUT_PAR, DATA_OUT_VALID, NXM, ADR_PAR_ERR, DATA_PAR_ERR;
    logic [0:35]  DATA_OUT;

    int errors = 0;
    int checks = 0;
    logic [35:0] model_mem [int];
    logic [35:0] exp_q [$];
    logic [35:0] beat_d [4];

    sbus_mem_responder #(
        .MEM_WORDS  (MEM_WORDS),
        .ACCESS_CYC (ACCESS_CYC)
    ) dut (
        .clk            (clk),
        .CROBAR         (CROBAR),
        .START          (START),
        .WR_RQ          (WR_RQ),
        .RQ             (RQ),
        .ADR            (ADR),
        .ADR_PAR        (ADR_PAR),
        .DATA_IN        (DATA_IN),
        .DATA_IN_PAR    (DATA_IN_PAR),
        .DATA_IN_VALID  (DATA_IN_VALID),
        .ACKN           (ACKN),
        .BUSY           (BUSY),
        .DATA_OUT       (DATA_OUT),
        .DATA_OUT_PAR   (DATA_OUT_PAR),
        .DATA_OUT_VALID (DATA_OUT_VALID),
        .NXM            (NXM),
        .ADR_PAR_ERR    (ADR_PAR_ERR),
        .DATA_PAR_ERR   (DATA_PAR_ERR)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives START for one cycle; returns in cycle t+1.
    task automatic start_req(input logic wr, input logic [0:3] rq, input logic [21:0] adr,
                             input logic bad_apar);
        START   = 1'b1;
        WR_RQ   = wr;
        RQ      = rq;
        ADR     = adr;
        ADR_PAR = (~^adr[21:2]) ^ bad_apar;
        step();
        START   = 1'b0;
    endtask

    // Write beats from beat_d in wrap order; reset_after >= 0 pulses CROBAR before that beat.
    task automatic do_write(input logic [21:0] adr, input logic [0:3] rq, input logic [3:0] badpar,
                            input int gap, input bit early_junk, input int reset_after);
        logic [1:0] slot;
        int         beat;
        int         wa;
        start_req(1'b1, rq, adr, 1'b0);
        checks++;
        if (ACKN !== 1'b1) begin
            errors++;
            $display("FAIL wr_ackn adr=%0o got=%b want=1", adr, ACKN);
        end
        step();
        for (int c = 0; c < ACCESS_CYC; c++) begin
            if (early_junk) begin
                DATA_IN_VALID = 1'b1;
                DATA_IN       = 36'o777000777000;
                DATA_IN_PAR   = ~^36'o777000777000;
            end
            step();
        end
        DATA_IN_VALID = 1'b0;
        beat = 0;
        for (int i = 0; i < 4; i++) begin
            slot = adr[1:0] + 2'(i);
            if (rq[slot]) begin
                if (beat == reset_after) begin
                    CROBAR = 1'b1;
                    step();
                    CROBAR = 1'b0;
                    checks++;
                    if (BUSY !== 1'b0 || ACKN !== 1'b0) begin
                        errors++;
                        $display("FAIL crobar_idle busy=%b ackn=%b want 0/0", BUSY, ACKN);
                    end
                    return;
                end
                if (beat > 0) repeat (gap) step();
                DATA_IN_VALID = 1'b1;
                DATA_IN       = beat_d[beat];
                DATA_IN_PAR   = (~^beat_d[beat]) ^ badpar[beat];
                step();
                DATA_IN_VALID = 1'b0;
                wa = int'({adr[21:2], slot});
                if (!(PAR_EN && badpar[beat])) model_mem[wa] = beat_d[beat];
                beat++;
            end
        end
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL wr_busy_end adr=%0o got=%b want=0", adr, BUSY);
        end
    endtask

    // Read with scoreboard; inject=1 raises START during the first beat.
    task automatic do_read(input logic [21:0] adr, input logic [0:3] rq, input bit inject);
        logic [1:0]  slot;
        logic [35:0] e;
        int wa, nexp, k, first, nbeats, acks, busy_end, zero_bad;
        exp_q.delete();
        nexp = 0;
        for (int i = 0; i < 4; i++) begin
            slot = adr[1:0] + 2'(i);
            if (rq[slot]) begin
                wa = int'({adr[21:2], slot});
                exp_q.push_back(model_mem.exists(wa) ? model_mem[wa] : 36'h0);
                nexp++;
            end
        end
        start_req(1'b0, rq, adr, 1'b0);
        checks++;
        if (ACKN !== 1'b1 || DATA_PAR_ERR !== 1'b0) begin
            errors++;
            $display("FAIL rd_ack adr=%0o ackn=%b dpe=%b want 1/0", adr, ACKN, DATA_PAR_ERR);
        end
        k = 1; first = -1; nbeats = 0; acks = 0; busy_end = -1; zero_bad = 0;
        while (k < 30) begin
            if (ACKN === 1'b1) acks++;
            if (DATA_OUT_VALID === 1'b1) begin
                nbeats++;
                if (first < 0) first = k;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_extra_beat adr=%0o got=%0o want none", adr, DATA_OUT);
                end else begin
                    e = exp_q.pop_front();
                    if (DATA_OUT !== e || DATA_OUT_PAR !== ~^e) begin
                        errors++;
                        $display("FAIL rd_data adr=%0o beat=%0d got=%0o/%b want=%0o/%b",
                                 adr, nbeats, DATA_OUT, DATA_OUT_PAR, e, ~^e);
                    end
                end
                if (inject && nbeats == 1) begin
                    START   = 1'b1;
                    WR_RQ   = 1'b1;
                    RQ      = 4'b1111;
                    ADR     = adr;
                    ADR_PAR = ~^adr[21:2];
                end
            end else if (DATA_OUT !== '0 || DATA_OUT_PAR !== 1'b0) begin
                zero_bad++;
            end
            if (BUSY !== 1'b1) begin
                busy_end = k;
                break;
            end
            step();
            START = 1'b0;
            k++;
        end
        START = 1'b0;
        checks++;
        if (busy_end < 0) begin
            errors++;
            $display("FAIL rd_timeout adr=%0o busy still high after %0d cycles", adr, k);
        end
        checks++;
        if (nbeats != nexp || acks != 1 || zero_bad != 0) begin
            errors++;
            $display("FAIL rd_counts adr=%0o beats=%0d acks=%0d zero_bad=%0d want %0d/1/0",
                     adr, nbeats, acks, zero_bad, nexp);
        end
        checks++;
        if (nexp > 0 && (first != 2 + ACCESS_CYC || busy_end != 2 + ACCESS_CYC + nexp)) begin
            errors++;
            $display("FAIL rd_timing adr=%0o first=%0d busy_end=%0d want %0d/%0d",
                     adr, first, busy_end, 2 + ACCESS_CYC, 2 + ACCESS_CYC + nexp);
        end else if (nexp == 0 && busy_end != 2) begin
            errors++;
            $display("FAIL rd_rq0_busy adr=%0o busy_end=%0d want 2", adr, busy_end);
        end
    endtask

    task automatic test_reset();
        CROBAR = 1'b1;
        repeat (3) step();
        checks++;
        if ({ACKN, BUSY, DATA_OUT_VALID, DATA_OUT_PAR, NXM, ADR_PAR_ERR, DATA_PAR_ERR} !== 7'b0
            || DATA_OUT !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b/%0o want 0/0",
                     {ACKN, BUSY, DATA_OUT_VALID, DATA_OUT_PAR, NXM, ADR_PAR_ERR, DATA_PAR_ERR},
                     DATA_OUT);
        end
        CROBAR = 1'b0;
        step();
        checks++;
        if (BUSY !== 1'b0 || ACKN !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b ackn=%b want 0/0", BUSY, ACKN);
        end
    endtask

    task automatic test_write_read();
        beat_d[0] = 36'd1; beat_d[1] = 36'd2; beat_d[2] = 36'd3; beat_d[3] = 36'd4;
        do_write(22'o100, 4'b1111, 4'b0000, 0, 1'b1, -1);
        do_read(22'o100, 4'b1111, 1'b0);
    endtask

    task automatic test_wrap_partial();
        do_read(22'o102, 4'b1010, 1'b0);
        beat_d[0] = 36'o555555555555; beat_d[1] = 36'o252525252525;
        do_write(22'o107, 4'b0110, 4'b0000, 3, 1'b0, -1);
        do_read(22'o105, 4'b0110, 1'b0);
    endtask

    task automatic test_nxm();
        start_req(1'b0, 4'b1111, 22'(MEM_WORDS), 1'b0);
        checks++;
        if (NXM !== 1'b1 || ACKN !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL nxm_pulse nxm=%b ackn=%b busy=%b want 1/0/0", NXM, ACKN, BUSY);
        end
        step();
        checks++;
        if (NXM !== 1'b0 || BUSY !== 1'b0 || ACKN !== 1'b0) begin
            errors++;
            $display("FAIL nxm_after nxm=%b busy=%b ackn=%b want 0/0/0", NXM, BUSY, ACKN);
        end
        beat_d[0] = 36'o123456701234;
        do_write(22'(MEM_WORDS - 1), 4'b0001, 4'b0000, 0, 1'b0, -1);
        do_read(22'(MEM_WORDS - 1), 4'b0001, 1'b0);
    endtask

    task automatic test_adr_par();
        start_req(1'b0, 4'b0000, 22'o400, 1'b1);
        checks++;
        if (ADR_PAR_ERR !== PAR_EN || ACKN !== !PAR_EN || NXM !== 1'b0) begin
            errors++;
            $display("FAIL adr_par ape=%b ackn=%b nxm=%b want %b/%b/0",
                     ADR_PAR_ERR, ACKN, NXM, PAR_EN, !PAR_EN);
        end
        step();
        checks++;
        if (ADR_PAR_ERR !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL adr_par_after ape=%b busy=%b want 0/0", ADR_PAR_ERR, BUSY);
        end
    endtask

    task automatic test_data_par();
        beat_d[0] = 36'd21; beat_d[1] = 36'd22; beat_d[2] = 36'd23; beat_d[3] = 36'd24;
        do_write(22'o200, 4'b1111, 4'b0000, 0, 1'b0, -1);
        beat_d[0] = 36'd31; beat_d[1] = 36'd32; beat_d[2] = 36'd33; beat_d[3] = 36'd34;
        do_write(22'o200, 4'b1111, 4'b0100, 1, 1'b0, -1);
        checks++;
        if (DATA_PAR_ERR !== PAR_EN) begin
            errors++;
            $display("FAIL data_par_sticky got=%b want=%b", DATA_PAR_ERR, PAR_EN);
        end
        do_read(22'o200, 4'b1111, 1'b0);
    endtask

    task automatic test_start_ignored();
        do_read(22'o100, 4'b1111, 1'b1);
        do_read(22'o100, 4'b0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_read(22'o101, 4'b1111, 1'b0);
        do_read(22'o102, 4'b1010, 1'b0);
        do_read(22'o200, 4'b0011, 1'b0);
    endtask

    task automatic test_crobar();
        beat_d[0] = 36'd11; beat_d[1] = 36'd12; beat_d[2] = 36'd13; beat_d[3] = 36'd14;
        do_write(22'o300, 4'b1111, 4'b0000, 0, 1'b0, -1);
        beat_d[0] = 36'd41; beat_d[1] = 36'd42; beat_d[2] = 36'd43; beat_d[3] = 36'd44;
        do_write(22'o300, 4'b1111, 4'b0000, 0, 1'b0, 2);
        do_read(22'o300, 4'b1111, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap_partial();
        test_nxm();
        test_adr_par();
        test_data_par();
        test_start_ignored();
        test_back_to_back();
        test_crobar();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
